// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared arbiter state encoding and default memory geometry
package dmem_arb_pkg;
    localparam int DMEM_AW = 13;
    localparam int DMEM_DW = 32;
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCK0,
        ARB_LOCK1
    } arb_state_e;
endpackage

// File: rtl/dmem_arb_rsp.sv
// dmem_arb_rsp: per-port read response, one-cycle valid pulse with data held until the next read
module dmem_arb_rsp import dmem_arb_pkg::*; #(
    parameter int DW = DMEM_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cap,
    input  logic [DW-1:0] i_data,
    output logic          o_rvalid,
    output logic [DW-1:0] o_rdata
);
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_cap;
            if (i_cap) r_rdata <= i_data;
        end
    end
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data memory arbiter with bounded ownership locking
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int LOCK_MAX = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_0,
    input  logic          i_we_0,
    input  logic [AW-1:0] i_addr_0,
    input  logic [DW-1:0] i_wdata_0,
    input  logic          i_lock_0,
    output logic          o_gnt_0,
    output logic          o_rvalid_0,
    output logic [DW-1:0] o_rdata_0,
    input  logic          i_req_1,
    input  logic          i_we_1,
    input  logic [AW-1:0] i_addr_1,
    input  logic [DW-1:0] i_wdata_1,
    input  logic          i_lock_1,
    output logic          o_gnt_1,
    output logic          o_rvalid_1,
    output logic [DW-1:0] o_rdata_1,
    output logic [AW-1:0] o_mem_A,
    output logic [DW-1:0] o_mem_WD,
    output logic          o_mem_WE,
    input  logic [DW-1:0] i_mem_RD
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e    r_state, w_state_nx;
    logic          r_ptr, w_ptr_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          w_gnt_0, w_gnt_1, w_lock;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_gnt_0    = 1'b0;
        w_gnt_1    = 1'b0;
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ARB_LOCK0: w_gnt_0 = i_req_0;
            ARB_LOCK1: w_gnt_1 = i_req_1;
            default: begin
                w_gnt_0 = i_req_0 & (~i_req_1 | ~r_ptr);
                w_gnt_1 = i_req_1 & (~i_req_0 | r_ptr);
            end
        endcase
        w_gnt_0 = w_gnt_0 & i_rst_n;
        w_gnt_1 = w_gnt_1 & i_rst_n;
        w_lock  = w_gnt_1 ? i_lock_1 : i_lock_0;
        // pointer always hands priority to the port that did not just win
        if (w_gnt_0 | w_gnt_1) begin
            w_ptr_nx = w_gnt_0;
            if (r_state == ARB_IDLE) begin
                if (w_lock && LOCK_MAX > 1) begin
                    w_state_nx = w_gnt_1 ? ARB_LOCK1 : ARB_LOCK0;
                    w_cnt_nx   = CW'(1);
                end
            end else begin
                w_cnt_nx = r_cnt + CW'(1);
                if (!w_lock || w_cnt_nx == CW'(LOCK_MAX)) begin
                    w_state_nx = ARB_IDLE;
                    w_cnt_nx   = '0;
                end
            end
        end else if ((r_state == ARB_LOCK0 && !i_req_0 && !i_lock_0) ||
                     (r_state == ARB_LOCK1 && !i_req_1 && !i_lock_1)) begin
            w_state_nx = ARB_IDLE;
            w_cnt_nx   = '0;
        end
    end

    assign o_gnt_0  = w_gnt_0;
    assign o_gnt_1  = w_gnt_1;
    assign o_mem_WE = (w_gnt_0 & i_we_0) | (w_gnt_1 & i_we_1);
    assign o_mem_A  = w_gnt_0 ? i_addr_0 : w_gnt_1 ? i_addr_1 : '0;
    assign o_mem_WD = w_gnt_0 ? i_wdata_0 : w_gnt_1 ? i_wdata_1 : '0;

    dmem_arb_rsp #(.DW(DW)) u_rsp_0 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_cap    (w_gnt_0 & ~i_we_0),
        .i_data   (i_mem_RD),
        .o_rvalid (o_rvalid_0),
        .o_rdata  (o_rdata_0)
    );

    dmem_arb_rsp #(.DW(DW)) u_rsp_1 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_cap    (w_gnt_1 & ~i_we_1),
        .i_data   (i_mem_RD),
        .o_rvalid (o_rvalid_1),
        .o_rdata  (o_rdata_1)
    );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, hand-written lock/reset sequences and random traffic against a reference model
module tb_dmem_arbiter;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LOCK_MAX = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req[2], we[2], lock[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd[2];
    logic          gnt[2], rv[2];
    logic [DW-1:0] rd[2];
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int n_chk = 0, n_fail = 0;
    int owner = -1, turn = 0, run = 0;
    logic          e_rv[2];
    logic [DW-1:0] e_rd[2];
    logic          cap_g[2], cap_rv[2];
    logic [DW-1:0] cap_rd[2];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;
    assign mem_rd = mem[mem_a];

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_0(req[0]), .i_we_0(we[0]), .i_addr_0(addr[0]), .i_wdata_0(wd[0]), .i_lock_0(lock[0]),
        .o_gnt_0(gnt[0]), .o_rvalid_0(rv[0]), .o_rdata_0(rd[0]),
        .i_req_1(req[1]), .i_we_1(we[1]), .i_addr_1(addr[1]), .i_wdata_1(wd[1]), .i_lock_1(lock[1]),
        .o_gnt_1(gnt[1]), .o_rvalid_1(rv[1]), .o_rdata_1(rd[1]),
        .o_mem_A(mem_a), .o_mem_WD(mem_wd), .o_mem_WE(mem_we), .i_mem_RD(mem_rd)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock: check against the model at negedge, then advance the model after posedge
    task automatic cyc();
        int win;
        @(negedge clk);
        win = -1;
        if (rst_n) begin
            if (owner >= 0) win = req[owner] ? owner : -1;
            else if (req[0] && req[1]) win = turn;
            else if (req[0]) win = 0;
            else if (req[1]) win = 1;
        end
        for (int p = 0; p < 2; p++) begin
            cap_g[p] = gnt[p];
            cap_rv[p] = rv[p];
            cap_rd[p] = rd[p];
            chk($sformatf("gnt%0d", p), gnt[p], win == p);
            chk($sformatf("rvalid%0d", p), rv[p], e_rv[p]);
            chk($sformatf("rdata%0d", p), rd[p], e_rd[p]);
        end
        chk("mem_we", mem_we, (win >= 0) ? we[win] : 1'b0);
        chk("mem_a", mem_a, (win >= 0) ? addr[win] : '0);
        chk("mem_wd", mem_wd, (win >= 0) ? wd[win] : '0);
        @(posedge clk);
        #1;
        e_rv[0] = 1'b0;
        e_rv[1] = 1'b0;
        if (!rst_n) begin
            owner = -1; turn = 0; run = 0;
            e_rd[0] = '0; e_rd[1] = '0;
        end else if (win >= 0) begin
            if (we[win]) ref_mem[addr[win]] = wd[win];
            else begin
                e_rv[win] = 1'b1;
                e_rd[win] = ref_mem[addr[win]];
            end
            turn = 1 - win;
            if (owner < 0) begin
                if (lock[win]) begin owner = win; run = 1; end
            end else begin
                run++;
                if (!lock[win] || run >= LOCK_MAX) owner = -1;
            end
        end else if (owner >= 0 && !req[owner] && !lock[owner]) owner = -1;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wd[p] = d;
    endtask

    typedef struct {
        logic [5:0]    ctl;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [3:0]    eg;
        logic [DW-1:0] rd0, rd1;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int n0;
        logic seen;
        logic pend[2];
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) * 32'h0100_0193;
        mem[13'h1FFF] = 32'hDEADBEEF;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
        e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();

        // ctl = {req0,req1,we0,we1,lock0,lock1}; eg = {gnt0,gnt1,rvalid0,rvalid1}
        tbl[0] = '{6'b111100, 13'h010, 13'h011, 32'hAAAA0000, 32'hBBBB1111, 4'b1000, 32'h0, 32'h0};
        tbl[1] = '{6'b010100, 13'h000, 13'h011, 32'h0, 32'hBBBB1111, 4'b0100, 32'h0, 32'h0};
        tbl[2] = '{6'b110000, 13'h011, 13'h010, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h0};
        tbl[3] = '{6'b010000, 13'h000, 13'h010, 32'h0, 32'h0, 4'b0110, 32'hBBBB1111, 32'h0};
        tbl[4] = '{6'b100000, 13'h1FFF, 13'h000, 32'h0, 32'h0, 4'b1001, 32'hBBBB1111, 32'hAAAA0000};
        tbl[5] = '{6'b111101, 13'h030, 13'h020, 32'h12345678, 32'h5, 4'b0110, 32'hDEADBEEF, 32'hAAAA0000};
        tbl[6] = '{6'b111101, 13'h030, 13'h021, 32'h12345678, 32'h6, 4'b0100, 32'hDEADBEEF, 32'hAAAA0000};
        tbl[7] = '{6'b111100, 13'h030, 13'h022, 32'h12345678, 32'h7, 4'b0100, 32'hDEADBEEF, 32'hAAAA0000};
        tbl[8] = '{6'b101000, 13'h030, 13'h000, 32'h12345678, 32'h0, 4'b1000, 32'hDEADBEEF, 32'hAAAA0000};
        tbl[9] = '{6'b000000, 13'h000, 13'h000, 32'h0, 32'h0, 4'b0000, 32'hDEADBEEF, 32'hAAAA0000};
        for (int i = 0; i < 10; i++) begin
            {req[0], req[1], we[0], we[1], lock[0], lock[1]} = tbl[i].ctl;
            addr[0] = tbl[i].a0; addr[1] = tbl[i].a1;
            wd[0] = tbl[i].d0; wd[1] = tbl[i].d1;
            cyc();
            chk($sformatf("vec%0d_flags", i), {cap_g[0], cap_g[1], cap_rv[0], cap_rv[1]}, tbl[i].eg);
            chk($sformatf("vec%0d_rd0", i), cap_rd[0], tbl[i].rd0);
            chk($sformatf("vec%0d_rd1", i), cap_rd[1], tbl[i].rd1);
        end

        // port 0 keeps the lock with both requesting until forced release
        drive(0, 1, 1, 1, 13'h040, 32'h1);
        drive(1, 0, 0, 0, '0, '0);
        cyc();
        n0 = cap_g[0] ? 1 : 0;
        seen = 1'b0;
        drive(1, 1, 1, 0, 13'h050, 32'h2);
        for (int k = 0; k < 40 && !seen; k++) begin
            addr[0] = 13'(13'h040 + k);
            cyc();
            if (cap_g[0]) n0++;
            if (cap_g[1]) seen = 1'b1;
        end
        chk("lockmax_grants0", 64'(n0), 64'd16);
        chk("lockmax_then_port1", seen, 1'b1);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        cyc();

        // reset while port 1 holds the lock and is reading
        drive(1, 1, 1, 1, 13'h060, 32'h3);
        cyc();
        drive(1, 1, 0, 1, 13'h060, '0);
        drive(0, 1, 0, 0, 13'h1FFF, '0);
        rst_n = 1'b0;
        cyc();
        chk("rst_no_gnt1", cap_g[1], 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_gnt0", cap_g[0], 1'b1);
        chk("post_rst_rv1", cap_rv[1], 1'b0);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        cyc();

        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int p = 0; p < 2; p++)
                if (!pend[p])
                    drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) == 0,
                          ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15)),
                          $urandom);
            cyc();
            for (int p = 0; p < 2; p++) pend[p] = req[p] && !cap_g[p];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13: data memory word-address width.
REQ-002 SHALL have parameter DW, default 32: data word width.
REQ-003 SHALL have parameter LOCK_MAX, default 16: maximum consecutive locked grants before forced release.
REQ-004 SHALL use one clock; reset is synchronous and active-low. Ports, clock and reset first, n in {0,1}:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_n  in  1  requester n access request.
- i_we_n  in  1  1 = write, 0 = read.
- i_addr_n  in  AW  word address.
- i_wdata_n  in  DW  write data.
- i_lock_n  in  1  keep ownership after this access.
- o_gnt_n  out  1  access accepted this cycle.
- o_rvalid_n  out  1  read data valid, one-cycle pulse.
- o_rdata_n  out  DW  read data.
- o_mem_A  out  AW  memory address.
- o_mem_WD  out  DW  memory write data.
- o_mem_WE  out  1  memory write enable.
- i_mem_RD  in  DW  memory combinational read data.

Function
REQ-005 SHALL grant at most one requester per cycle; o_gnt_n is combinational from state and i_req_*; a grant occurs only where i_req_n=1.
REQ-006 Requester SHALL hold i_req_n, i_we_n, i_addr_n, i_wdata_n and i_lock_n stable until o_gnt_n=1; the transfer completes in the grant cycle.
REQ-007 In the grant cycle, SHALL drive o_mem_A/o_mem_WD from the winner and set o_mem_WE=i_we_n; with no grant, o_mem_WE=0, o_mem_A=0, o_mem_WD=0.
REQ-008 A granted write SHALL commit at the same posedge; no rvalid is produced.
REQ-009 A granted read SHALL capture i_mem_RD into o_rdata_n at the grant posedge and pulse o_rvalid_n for exactly the next cycle (latency 1); o_rdata_n holds until the next read for port n.
REQ-010 FSM states SHALL be ARB_IDLE, ARB_LOCK0 and ARB_LOCK1.
REQ-011 In ARB_IDLE, round-robin: a single requester wins; with both requesting, the holder of the priority pointer wins; after any grant to n, the pointer moves to the other port.
REQ-012 A grant to n in ARB_IDLE with i_lock_n=1 SHALL move to ARB_LOCKn and load lock count 1.
REQ-013 In ARB_LOCKn, only port n SHALL be granted; the other port stalls, even when port n is idle.
REQ-014 ARB_LOCKn SHALL exit to ARB_IDLE on a grant to n with i_lock_n=0, or on a cycle with i_req_n=0 and i_lock_n=0.
REQ-015 Each locked grant SHALL increment the lock count; the grant that makes the count equal LOCK_MAX SHALL force ARB_IDLE, with the pointer set to the other port, regardless of i_lock_n.
REQ-016 The lock counter SHALL be $clog2(LOCK_MAX+1) bits wide and SHALL never wrap.
REQ-017 Simultaneous requests on the force-release cycle: the locked port is granted that cycle; the other port wins the next cycle.
REQ-018 A read pulse on one port and a grant on the other port SHALL proceed concurrently, with no extra stall.

Reset
REQ-019 With i_rst_n=0 at posedge: state ARB_IDLE, pointer to port 0, lock count 0; o_gnt_*=0, o_rvalid_*=0, o_rdata_*=0, o_mem_WE=0, o_mem_A=0, o_mem_WD=0.
REQ-020 Reset during a lock or a pending rvalid SHALL drop it; no rvalid pulse follows reset.
REQ-021 While i_rst_n=0, grants SHALL be 0 irrespective of requests.

Structure
REQ-022 Package dmem_arb_pkg SHALL hold typedef arb_state_e and the default AW/DW constants.
REQ-023 Per-port read-response register SHALL be sub-module dmem_arb_rsp, instantiated twice.
REQ-024 The arbiter SHALL contain no memory array; the memory array is instantiated beside it.

Verification
REQ-025 Reset: reset then release with no requests -> all outputs 0, o_mem_WE=0 for 10 cycles.
REQ-026 Both ports write with no lock (port 0 to 0x010 = 0xAAAA0000, port 1 to 0x011 = 0xBBBB1111) -> grants port 0 then port 1 on consecutive cycles; readback returns both values.
REQ-027 Port 0 reads 0x1FFF holding 0xDEADBEEF -> o_gnt_0 at cycle T; o_rvalid_0=1 with o_rdata_0=0xDEADBEEF at T+1 only.
REQ-028 Port 1 holds lock for 3 accesses while port 0 requests -> port 0 stalls 3 cycles and is granted on cycle 4.
REQ-029 Port 0 holds lock with continuous requests, LOCK_MAX=16 -> 16 grants to port 0, then port 1 is granted next.
REQ-030 Reset asserted in ARB_LOCK1 mid-read -> no o_rvalid_1 pulse; first post-reset collision grants port 0.
